// File: rtl/comp_pkg.sv
// Shared definitions for the bit-serial magnitude comparator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding and one-hot result codes {gt, eq, lt}.
package comp_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;
  localparam logic [2:0] RES_NONE = 3'b000;

endpackage

// File: rtl/comp1_cell.sv
// One-bit magnitude comparator cell; purely combinational.
// Latency: 0 cycles.
// Backpressure: none.
// Ports: x, y - bits under test; g = x>y, e = x==y, l = x<y (exactly one high).
module comp1_cell (
  input  logic x,
  input  logic y,
  output logic g,
  output logic e,
  output logic l
);

  assign g = x & ~y;
  assign l = ~x & y;
  assign e = ~(x ^ y);

endmodule

// File: rtl/serial_comp_ctrl.sv
// Bit-serial magnitude comparator: walks ra/rb MSB first through one comp1_cell, stops at the first differing bit.
// Latency: done pulses bits_used+1 cycles after the accepting edge (WIDTH+1 for equal operands).
// Backpressure: start accepted only in IDLE or DONE; start while busy is dropped, nothing is queued.
// Ports: clk, rst_n (async active-low); start, a, b (request); busy, done, gt, eq, lt, bits_used (status/result).
module serial_comp_ctrl
  import comp_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [CW-1:0]    bits_used
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] ra, ra_nx;
  logic [WIDTH-1:0] rb, rb_nx;
  logic [IW-1:0]    idx, idx_nx;
  logic [2:0]       res, res_nx;
  logic [CW-1:0]    bits, bits_nx;

  logic cell_g, cell_e, cell_l;

  comp1_cell u_cell (
    .x (ra[idx]),
    .y (rb[idx]),
    .g (cell_g),
    .e (cell_e),
    .l (cell_l)
  );

  // Reset release is assumed already synchronised to clk upstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ra    <= '0;
      rb    <= '0;
      idx   <= '0;
      res   <= RES_NONE;
      bits  <= '0;
    end else begin
      state <= state_nx;
      ra    <= ra_nx;
      rb    <= rb_nx;
      idx   <= idx_nx;
      res   <= res_nx;
      bits  <= bits_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ra_nx    = ra;
    rb_nx    = rb;
    idx_nx   = idx;
    res_nx   = res;
    bits_nx  = bits;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          ra_nx    = a;
          rb_nx    = b;
          idx_nx   = IDX_MSB;
          res_nx   = RES_NONE;
          bits_nx  = '0;
          state_nx = S_SHIFT;
        end else if (state == S_DONE) begin
          state_nx = S_IDLE;
        end
      end

      S_SHIFT: begin
        bits_nx = bits + CW'(1);
        if (!cell_e) begin
          // First differing bit decides the result outright.
          res_nx   = {cell_g, 1'b0, cell_l};
          state_nx = S_DONE;
        end else if (idx == '0) begin
          // Every position matched; idx==0 always leaves SHIFT so idx never wraps.
          res_nx   = RES_EQ;
          state_nx = S_DONE;
        end else begin
          idx_nx = idx - IW'(1);
        end
      end

      default: state_nx = S_IDLE;
    endcase
  end

  assign busy      = (state == S_SHIFT);
  assign done      = (state == S_DONE);
  assign gt        = res[2];
  assign eq        = res[1];
  assign lt        = res[0];
  assign bits_used = bits;

endmodule

// File: tb/tb_serial_comp_ctrl.sv
module tb_serial_comp_ctrl;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH) + 1;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;
  logic [CW-1:0]    bits_used;

  serial_comp_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .gt        (gt),
    .eq        (eq),
    .lt        (lt),
    .bits_used (bits_used)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Number of bit positions a MSB-first scan touches before deciding.
  function automatic int scan_len(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    for (int i = WIDTH - 1; i >= 0; i--)
      if (x[i] != y[i]) return WIDTH - i;
    return WIDTH;
  endfunction

  // Behavioural model: a countdown of remaining scan cycles, results from plain arithmetic.
  int               m_left;
  int               m_bits;
  bit               m_done;
  bit [2:0]         m_res;
  logic [WIDTH-1:0] m_a, m_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_bits = 0; m_done = 0; m_res = 3'b000; m_a = '0; m_b = '0;
    end else if (m_left > 0) begin
      m_left--;
      m_bits++;
      if (m_left == 0) begin
        m_done = 1;
        m_res  = (m_a > m_b) ? 3'b100 : (m_a == m_b) ? 3'b010 : 3'b001;
      end
    end else begin
      m_done = 0;
      if (start) begin
        m_a = a; m_b = b;
        m_left = scan_len(a, b);
        m_bits = 0;
        m_res  = 3'b000;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("cyc_busy", busy, (m_left > 0) ? 1 : 0);
    chk("cyc_done", done, m_done);
    chk("cyc_res", {gt, eq, lt}, m_res);
    chk("cyc_bits", bits_used, m_bits);
  end

  int cyc;
  int busyc;

  task automatic step();
    @(negedge clk);
    cyc++;
    if (busy) busyc++;
  endtask

  // Present a request; returns at cycle 1 (first negedge after the accepting edge).
  task automatic launch(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb);
    @(negedge clk);
    a = xa; b = xb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    busyc = busy ? 1 : 0;
  endtask

  task automatic finish(input string nm, input logic [2:0] eres, input int ebits, input int edone);
    while (!done && cyc < 25) step();
    chk({nm, "_done_cycle"}, done ? cyc : -1, edone);
    chk({nm, "_res"}, {gt, eq, lt}, eres);
    chk({nm, "_bits"}, bits_used, ebits);
    chk({nm, "_busy_cycles"}, busyc, ebits);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #22;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", {gt, eq, lt}, 0);
    chk("rst_bits", bits_used, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Differs at bit 7: one bit examined, done at cycle 2.
    launch(8'hA5, 8'h25);
    finish("a5_25", 3'b100, 1, 2);

    // Equal operands: full scan.
    launch(8'h3C, 8'h3C);
    finish("3c_3c", 3'b010, 8, 9);

    // Differs only at bit 0.
    launch(8'h10, 8'h11);
    finish("10_11", 3'b001, 8, 9);

    // start while busy is dropped.
    launch(8'h01, 8'h01);
    step(); step();
    a = 8'hFF; b = 8'h00; start = 1'b1;
    step();
    start = 1'b0; a = 8'h00; b = 8'h00;
    finish("ignore_busy", 3'b010, 8, 9);

    // Back-to-back: start held through DONE re-accepts with no IDLE cycle.
    launch(8'hA5, 8'h25);
    a = 8'h00; b = 8'h80; start = 1'b1;
    step();
    chk("b2b_first_done", done, 1);
    chk("b2b_first_res", {gt, eq, lt}, 3'b100);
    step();
    start = 1'b0;
    chk("b2b_busy_again", busy, 1);
    chk("b2b_res_cleared", {gt, eq, lt}, 0);
    chk("b2b_bits_cleared", bits_used, 0);
    cyc = 1; busyc = 1;
    finish("b2b_second", 3'b001, 1, 2);

    // Asynchronous reset in the middle of an equal-operand scan.
    launch(8'h3C, 8'h3C);
    step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_res", {gt, eq, lt}, 0);
    chk("arst_bits", bits_used, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    busyc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy || done) busyc++;
    end
    chk("arst_stays_idle", busyc, 0);

    // Normal operation after the abort.
    launch(8'h81, 8'h7F);
    finish("post_rst", 3'b100, 1, 2);
    launch(8'h80, 8'h81);
    finish("post_rst_lt", 3'b001, 8, 9);

    // Results held through IDLE.
    repeat (3) @(negedge clk);
    chk("held_res", {gt, eq, lt}, 3'b001);
    chk("held_bits", bits_used, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
